// File: rtl/pipelined_addertree_acc.sv
// Registered binary adder tree (LEVELS stages) feeding a multi-beat accumulator; in_last -> out_valid after LEVELS+1 cycles.
// A held output (out_valid && !out_ready) freezes every stage; define ADDERTREE_SATURATE_EN to clamp instead of wrap on narrowing.
module pipelined_addertree_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 42,
  parameter int MAX_BEATS  = 16,
  parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(LENGTH) + $clog2(MAX_BEATS)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [LENGTH-1:0][DATA_WIDTH-1:0]    in_addends_i,
  input  logic                                 in_last_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  output logic signed [OUT_WIDTH-1:0]          out_sum_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 out_err_o,
  output logic                                 out_sat_o
);

  localparam int LEVELS    = $clog2(LENGTH);
  localparam int ACC_WIDTH = DATA_WIDTH + LEVELS + $clog2(MAX_BEATS);
  localparam int TW        = DATA_WIDTH + LEVELS;
  localparam int NL        = (LEVELS > 0) ? LEVELS : 1;
  localparam int CW        = $clog2(MAX_BEATS + 1);

  function automatic int cnt_at(input int k);
    int n;
    n = LENGTH;
    for (int j = 0; j < k; j++) n = (n + 1) / 2;
    return n;
  endfunction

  logic                        stall;
  logic signed [TW-1:0]        lvl0   [LENGTH];
  logic signed [TW-1:0]        cur    [LENGTH];
  logic signed [TW-1:0]        tree_d [NL][LENGTH];
  logic signed [TW-1:0]        tree_q [NL][LENGTH];
  logic [NL-1:0]               vld_q, last_q;
  logic signed [TW-1:0]        tree_sum;
  logic                        tree_vld, tree_last;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, base_acc;
  logic [CW-1:0]               cnt_q, cnt_d, base_cnt;
  logic                        err_q, err_d, first_q;
  logic                        out_valid_q, out_err_q, out_sat_q, out_sat_d;
  logic signed [OUT_WIDTH-1:0] out_sum_q, out_sum_d;

  assign stall      = out_valid_q && !out_ready_i;
  assign in_ready_o = !stall;

  always_comb begin
    for (int i = 0; i < LENGTH; i++) lvl0[i] = TW'($signed(in_addends_i[i]));
  end

  // Each level pairs neighbours; an odd trailing element passes straight through.
  always_comb begin
    tree_d = '{default: '0};
    cur    = lvl0;
    for (int k = 0; k < LEVELS; k++) begin
      if (k == 0) cur = lvl0;
      else        cur = tree_q[k-1];
      for (int i = 0; i < LENGTH; i++) begin
        if (2*i + 1 < cnt_at(k))       tree_d[k][i] = cur[2*i] + cur[2*i+1];
        else if (2*i + 1 == cnt_at(k)) tree_d[k][i] = cur[2*i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tree_q <= '{default: '0};
      vld_q  <= '0;
      last_q <= '0;
    end else if (!stall) begin
      tree_q    <= tree_d;
      vld_q[0]  <= in_valid_i;
      last_q[0] <= in_last_i;
      for (int k = 1; k < NL; k++) begin
        vld_q[k]  <= vld_q[k-1];
        last_q[k] <= last_q[k-1];
      end
    end
  end

  generate
    if (LEVELS == 0) begin : g_flat
      always_comb begin
        tree_sum  = lvl0[0];
        tree_vld  = in_valid_i;
        tree_last = in_last_i;
      end
    end else begin : g_tree
      always_comb begin
        tree_sum  = tree_q[LEVELS-1][0];
        tree_vld  = vld_q[LEVELS-1];
        tree_last = last_q[LEVELS-1];
      end
    end
  endgenerate

  always_comb begin
    base_acc = first_q ? '0 : acc_q;
    base_cnt = first_q ? '0 : cnt_q;
    acc_d    = base_acc + ACC_WIDTH'(tree_sum);
    err_d    = (!first_q && err_q) || (base_cnt == CW'(MAX_BEATS));
    cnt_d    = (base_cnt == CW'(MAX_BEATS)) ? base_cnt : base_cnt + CW'(1);
  end

`ifdef ADDERTREE_SATURATE_EN
  logic signed [ACC_WIDTH-1:0] acc_hi;
  always_comb begin
    acc_hi    = acc_d >>> (OUT_WIDTH - 1);
    out_sat_d = 1'b0;
    out_sum_d = acc_d[OUT_WIDTH-1:0];
    // Upper bits not all equal to the sign bit means the value does not fit.
    if (!(acc_hi == '0 || acc_hi == '1)) begin
      out_sat_d = 1'b1;
      out_sum_d = acc_d[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    out_sum_d = acc_d[OUT_WIDTH-1:0];
    out_sat_d = 1'b0;
  end
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_err_q   <= 1'b0;
      out_sat_q   <= 1'b0;
    end else if (!stall) begin
      if (tree_vld) begin
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        err_q   <= err_d;
        first_q <= tree_last;
      end
      out_valid_q <= tree_vld && tree_last;
      if (tree_vld && tree_last) begin
        out_sum_q <= out_sum_d;
        out_err_q <= err_d;
        out_sat_q <= out_sat_d;
      end
    end
  end

  assign out_sum_o   = out_sum_q;
  assign out_valid_o = out_valid_q;
  assign out_err_o   = out_err_q;
  assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_pipelined_addertree_acc.sv
// Directed bench: four instances (base, 8-bit output, MAX_BEATS=2, LENGTH=3) share one stimulus stream.
module tb_pipelined_addertree_acc;

  logic clk = 1'b0;
  logic reset;
  logic [3:0][7:0] add;
  logic in_last, in_valid, out_ready;

  logic signed [11:0] sum_a;  logic ov_a, ir_a, err_a, sat_a;
  logic signed [7:0]  sum_b;  logic ov_b, ir_b, err_b, sat_b;
  logic signed [10:0] sum_c;  logic ov_c, ir_c, err_c, sat_c;
  logic signed [11:0] sum_d;  logic ov_d, ir_d, err_d, sat_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_addertree_acc #(.DATA_WIDTH(8), .LENGTH(4), .MAX_BEATS(4)) u_a (
    .clk_i(clk), .reset_i(reset), .in_addends_i(add), .in_last_i(in_last), .in_valid_i(in_valid),
    .in_ready_o(ir_a), .out_sum_o(sum_a), .out_valid_o(ov_a), .out_ready_i(out_ready),
    .out_err_o(err_a), .out_sat_o(sat_a));

  pipelined_addertree_acc #(.DATA_WIDTH(8), .LENGTH(4), .MAX_BEATS(4), .OUT_WIDTH(8)) u_b (
    .clk_i(clk), .reset_i(reset), .in_addends_i(add), .in_last_i(in_last), .in_valid_i(in_valid),
    .in_ready_o(ir_b), .out_sum_o(sum_b), .out_valid_o(ov_b), .out_ready_i(out_ready),
    .out_err_o(err_b), .out_sat_o(sat_b));

  pipelined_addertree_acc #(.DATA_WIDTH(8), .LENGTH(4), .MAX_BEATS(2)) u_c (
    .clk_i(clk), .reset_i(reset), .in_addends_i(add), .in_last_i(in_last), .in_valid_i(in_valid),
    .in_ready_o(ir_c), .out_sum_o(sum_c), .out_valid_o(ov_c), .out_ready_i(out_ready),
    .out_err_o(err_c), .out_sat_o(sat_c));

  pipelined_addertree_acc #(.DATA_WIDTH(8), .LENGTH(3), .MAX_BEATS(4)) u_d (
    .clk_i(clk), .reset_i(reset), .in_addends_i(add[2:0]), .in_last_i(in_last), .in_valid_i(in_valid),
    .in_ready_o(ir_d), .out_sum_o(sum_d), .out_valid_o(ov_d), .out_ready_i(out_ready),
    .out_err_o(err_d), .out_sat_o(sat_d));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int a0, input int a1, input int a2, input int a3, input bit last);
    add[0]   = 8'(a0);
    add[1]   = 8'(a1);
    add[2]   = 8'(a2);
    add[3]   = 8'(a3);
    in_last  = last;
    in_valid = 1'b1;
  endtask

  // Called at a negedge with out_ready high: the beat is accepted on the next posedge.
  task automatic beat(input int a0, input int a1, input int a2, input int a3, input bit last);
    set_beat(a0, a1, a2, a3, last);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input int max_cyc);
    for (int i = 0; i < max_cyc && ov_a !== 1'b1; i++) @(negedge clk);
    chk("result_timeout", ov_a, 1);
  endtask

  initial begin
    int sent, got, stalls;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; add = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", ov_a, 0);
    chk("rst_sum", $signed(sum_a), 0);
    chk("rst_err", err_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_in_ready", ir_a, 1);
    reset = 1'b0;
    @(negedge clk);

    // single beat, exact latency of LEVELS+1
    beat(1, 1, 1, 1, 1);
    chk("lat_t1", ov_a, 0);
    @(negedge clk);
    chk("lat_t2", ov_a, 0);
    @(negedge clk);
    chk("lat_t3_valid", ov_a, 1);
    chk("lat_sum", $signed(sum_a), 4);
    chk("lat_err", err_a, 0);
    chk("lat_sat", sat_a, 0);
    @(negedge clk);
    chk("lat_drop", ov_a, 0);

    // two-beat vector of minimum values
    beat(-128, -128, -128, -128, 0);
    beat(-128, -128, -128, -128, 1);
    chk("two_mid1", ov_a, 0);
    @(negedge clk);
    chk("two_mid2", ov_a, 0);
    @(negedge clk);
    chk("two_valid", ov_a, 1);
    chk("two_sum", $signed(sum_a), -1024);
    @(negedge clk);

    // mixed signs; the LENGTH=3 instance exercises the odd pass-through
    beat(10, -3, 7, -20, 1);
    wait_result(6);
    chk("mix_sum4", $signed(sum_a), -6);
    chk("mix_sum3", $signed(sum_d), 14);
    @(negedge clk);

    // streaming with a 5-cycle output stall
    sent = 0; got = 0; stalls = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 11);
      if (sent < 8) set_beat(sent + 1, sent + 1, sent + 1, sent + 1, 1);
      else begin in_valid = 1'b0; in_last = 1'b0; end
      #1;
      if (ov_a && !out_ready) begin
        stalls++;
        chk("stall_in_ready", ir_a, 0);
        chk("stall_sum", $signed(sum_a), 4 * (got + 1));
      end
      if (ov_a && out_ready) begin
        chk("stream_sum", $signed(sum_a), 4 * (got + 1));
        got++;
      end
      if (in_valid && ir_a) sent++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    chk("stream_count", got, 8);
    chk("stall_cycles", stalls, 5);
    @(negedge clk);

    // reset in the middle of a vector
    beat(5, 5, 5, 5, 0);
    beat(5, 5, 5, 5, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", ov_a, 0);
    @(negedge clk);
    chk("mid_rst_valid2", ov_a, 0);
    reset = 1'b0;
    beat(2, 2, 2, 2, 1);
    wait_result(6);
    chk("post_rst_sum", $signed(sum_a), 8);
    chk("post_rst_err", err_a, 0);
    @(negedge clk);

    // narrowing to 8 bits
    beat(100, 100, 100, 100, 1);
    wait_result(6);
    chk("wide_sum", $signed(sum_a), 400);
    chk("wide_sat", sat_a, 0);
`ifdef ADDERTREE_SATURATE_EN
    chk("narrow_sum", $signed(sum_b), 127);
    chk("narrow_sat", sat_b, 1);
`else
    chk("narrow_sum", $signed(sum_b), -112);
    chk("narrow_sat", sat_b, 0);
`endif
    @(negedge clk);

    // beat-count overflow on the MAX_BEATS=2 instance
    beat(1, 1, 1, 1, 0);
    beat(1, 1, 1, 1, 0);
    beat(1, 1, 1, 1, 1);
    wait_result(6);
    chk("ovf_sum", $signed(sum_c), 12);
    chk("ovf_err", err_c, 1);
    chk("ovf_err_max4", err_a, 0);
    @(negedge clk);
    beat(1, 1, 1, 1, 1);
    wait_result(6);
    chk("ovf_clear_sum", $signed(sum_c), 4);
    chk("ovf_clear_err", err_c, 0);
    @(negedge clk);
    beat(1, 1, 1, 1, 0);
    beat(1, 1, 1, 1, 1);
    wait_result(6);
    chk("max_beats_sum", $signed(sum_c), 8);
    chk("max_beats_err", err_c, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
